// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stage enables, flushes and bubbles for load-use, branch and memory-wait hazards.
// Optional build macro HAZARD_STATS_EN adds saturating hazard event counters with a stat_clr input.
//   state      | meaning
//   S_RUN      | pipeline flowing; hazards resolved by priority
//   S_MEM_WAIT | pipeline frozen until mem_ready or timeout
module pipe_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] if_id_rs,
  input  logic [REG_AW-1:0] if_id_rt,
  input  logic              if_id_uses_rt,
  input  logic              id_ex_memread,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic              branch_taken,
  input  logic              ex_mem_memrd,
  input  logic              ex_mem_memwr,
  input  logic              mem_ready,
`ifdef HAZARD_STATS_EN
  input  logic              stat_clr,
  output logic [31:0]       stat_lu_stalls,
  output logic [31:0]       stat_br_flushes,
  output logic [31:0]       stat_mem_wait,
`endif
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_flush,
  output logic              ex_mem_en,
  output logic              mem_wb_bubble,
  output logic              mem_err
);

  localparam logic [0:0] S_RUN      = 1'b0;
  localparam logic [0:0] S_MEM_WAIT = 1'b1;
  localparam logic [TMO_W-1:0] TMO  = TMO_W'(MEM_TIMEOUT);

  logic [0:0]       state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             mem_req, load_use, flow;

  assign mem_req  = ex_mem_memrd | ex_mem_memwr;
  assign load_use = id_ex_memread && (id_ex_rd != '0) &&
                    ((id_ex_rd == if_id_rs) || (if_id_uses_rt && (id_ex_rd == if_id_rt)));
  assign mem_err  = err_q;

  always_comb begin
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_en     = 1'b0;
    mem_wb_bubble = 1'b0;
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    flow          = 1'b0;
    case (state_q)
      S_RUN: begin
        if (mem_req && !mem_ready) begin
          mem_wb_bubble = 1'b1;
          state_d       = S_MEM_WAIT;
          cnt_d         = TMO_W'(1);
        end else begin
          flow = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (mem_ready) begin
          flow    = 1'b1;
          state_d = S_RUN;
          cnt_d   = '0;
        end else if (cnt_q >= TMO) begin
          // abandon the access: faulting op leaves EX/MEM without writeback
          ex_mem_en     = 1'b1;
          mem_wb_bubble = 1'b1;
          err_d         = 1'b1;
          state_d       = S_RUN;
          cnt_d         = '0;
        end else begin
          mem_wb_bubble = 1'b1;
          cnt_d         = cnt_q + TMO_W'(1);
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
    if (flow) begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      if (branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
    if (!rst_n) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic        lu_evt, br_evt, mw_evt;
  logic [31:0] lu_q, br_q, mw_q;

  assign lu_evt = flow && !branch_taken && load_use;
  assign br_evt = flow && branch_taken;
  assign mw_evt = (state_q == S_MEM_WAIT);
  assign stat_lu_stalls  = lu_q;
  assign stat_br_flushes = br_q;
  assign stat_mem_wait   = mw_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_q <= '0;
      br_q <= '0;
      mw_q <= '0;
    end else if (stat_clr) begin
      lu_q <= '0;
      br_q <= '0;
      mw_q <= '0;
    end else begin
      if (lu_evt && !(&lu_q)) lu_q <= lu_q + 32'd1;
      if (br_evt && !(&br_q)) br_q <= br_q + 32'd1;
      if (mw_evt && !(&mw_q)) mw_q <= mw_q + 32'd1;
    end
  end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates per-stage enable and flush/bubble controls.
- Handles three hazard types: load-use stalls, taken-branch flushes, and multi-cycle data-memory waits, with a timeout on the memory wait.
- Sits beside the datapath; consumes hazard-relevant fields already registered in IF/ID, ID/EX and EX/MEM.

Parameters:
- REG_AW, 5, register-address width.
- MEM_TIMEOUT, 16, maximum MEM_WAIT cycles before abort (must be >= 1).
- TMO_W, 5, width of the wait counter (must hold MEM_TIMEOUT).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_id_rs  in  REG_AW  rs field of the instruction in IF/ID.
- if_id_rt  in  REG_AW  rt field of the instruction in IF/ID.
- if_id_uses_rt  in  1  instruction in IF/ID reads rt.
- id_ex_memread  in  1  ID/EX M-bit for load.
- id_ex_rd  in  REG_AW  destination register held in ID/EX.
- branch_taken  in  1  branch resolved taken in EX this cycle.
- ex_mem_memrd  in  1  EX/MEM M-bit for memory read.
- ex_mem_memwr  in  1  EX/MEM M-bit for memory write.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC load enable.
- if_id_en  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID cleared to NOP on the next edge.
- id_ex_en  out  1  ID/EX register enable.
- id_ex_flush  out  1  ID/EX WB/M bits cleared (bubble).
- ex_mem_en  out  1  EX/MEM register enable.
- mem_wb_bubble  out  1  MEM/WB loads WB=0.
- mem_err  out  1  sticky memory-timeout flag.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State RUN; wait counter 0; mem_err 0.
  - Outputs while rst_n=0: all *_en=0; if_id_flush=id_ex_flush=mem_wb_bubble=1.
- State RUN, first-matching priority:
  1. mem_req = ex_mem_memrd|ex_mem_memwr. If mem_req and !mem_ready: go to MEM_WAIT this cycle; pc_en=if_id_en=id_ex_en=ex_mem_en=0; mem_wb_bubble=1; wait counter loads 1.
  2. branch_taken: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_flush=1. Any load-use condition this cycle is ignored, because the consumer is on the wrong path.
  3. Load-use: id_ex_memread && id_ex_rd!=0 && (id_ex_rd==if_id_rs || (if_id_uses_rt && id_ex_rd==if_id_rt)). Then pc_en=0, if_id_en=0, id_ex_flush=1. Exactly one bubble; the condition clears naturally the next cycle.
  4. Otherwise all enables 1, all flush/bubble 0.
  - mem_req with mem_ready=1 in the same cycle is a zero-wait access: no stall.
- State MEM_WAIT:
  - Pipeline frozen: all enables 0, mem_wb_bubble=1. Branch/load-use inputs are ignored; they are held by the frozen registers and re-evaluated after exit.
  - mem_ready=1: outputs are as in RUN row 2–4 evaluation for this cycle, with ex_mem_en=1 and mem_wb_bubble=0. Next state RUN; counter cleared.
  - Counter reaching MEM_TIMEOUT with mem_ready=0:
    - mem_err set (sticky until reset).
    - Access abandoned: this cycle ex_mem_en=1 and mem_wb_bubble=1, so the faulting op retires with no writeback.
    - Next state RUN.
  - Otherwise the counter increments, saturating at MEM_TIMEOUT.
- Latency and timing:
  - All controls are combinational from the current state and inputs; they take effect on the next rising edge.
  - FSM/counter update on the rising edge.
  - Wait penalty = number of cycles mem_ready is low.
  - Load-use penalty = 1 cycle. Branch penalty = 2 cycles (2 flushed slots).
- Reset asserted mid-MEM_WAIT: immediate return to RUN, counter cleared, mem_err cleared.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, three additional 32-bit outputs: stat_lu_stalls, stat_br_flushes, stat_mem_wait.
  - stat_lu_stalls increments on each load-use bubble.
  - stat_br_flushes increments on each taken-branch flush.
  - stat_mem_wait increments on each cycle in MEM_WAIT.
  - All are saturating, cleared by rst_n, and also cleared by a 1-cycle input stat_clr. When stat_clr coincides with an increment, the clear wins.
- When undefined, these ports and the counter logic are absent, and behaviour is otherwise identical.

Test Plan:
- Load-use: id_ex_memread=1, id_ex_rd=8, if_id_rs=8 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1, then all enables 1. Repeat with id_ex_rd=0 -> no stall.
- Branch vs load-use: branch_taken=1 with a load-use match in the same cycle -> pc_en=1, if_id_flush=1, id_ex_flush=1, no stall.
- Memory wait: ex_mem_memrd=1, mem_ready low for 3 cycles then high -> 3 frozen cycles with mem_wb_bubble=1; on the ready cycle ex_mem_en=1 and mem_wb_bubble=0; then RUN.
- Zero-wait: ex_mem_memwr=1 and mem_ready=1 together -> no stall cycle.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_err rises on the 4th wait cycle and stays high; return to RUN with no writeback of the faulting op.
- Async reset: drop rst_n mid-MEM_WAIT, away from a clock edge -> enables go to 0 immediately; after release state is RUN and mem_err=0.
